// File: rtl/board_vga_pkg.sv
// Shared geometry, colour and region definitions for the board compositor.
package board_vga_pkg;

  localparam int unsigned TILE_SIZE  = 108;
  localparam int unsigned TILE_GAP   = 8;
  localparam int unsigned TILE_PITCH = 116;
  localparam int unsigned BOARD_X0   = 84;
  localparam int unsigned BOARD_Y0   = 4;
  // Four tiles plus five gaps, outer gaps included.
  localparam int unsigned BOARD_SPAN = 472;
  localparam int unsigned RENDER_LAT = 2;
  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned V_ACTIVE   = 480;

  localparam logic [11:0] COL_GAP     = 12'hBAA;
  localparam logic [11:0] COL_OUTSIDE = 12'hFEE;
  localparam logic [11:0] COL_OFF     = 12'h000;

  typedef enum logic [1:0] {OFF, OUTSIDE, GAP, TILE} region_e;

endpackage

// File: rtl/tile_axis_counter.sv
// Per-axis tile position tracker: local count, tile index and in-tile flag for the current count.
module tile_axis_counter #(
  parameter int unsigned Origin = 92,
  parameter int unsigned Size   = 108,
  parameter int unsigned Pitch  = 116
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cnt,
  input  logic        adv,
  output logic [11:0] local_cnt,
  output logic [1:0]  index,
  output logic        in_tile
);

  logic [11:0] local_q, local_d;
  logic [1:0]  index_q, index_d;

  // local_d/index_d describe the current cnt; the registers hold the last advanced position.
  always_comb begin
    local_d = local_q;
    index_d = index_q;
    if (adv) begin
      if (cnt == 12'(Origin)) begin
        local_d = '0;
        index_d = '0;
      end else if (local_q == 12'(Pitch - 1)) begin
        local_d = '0;
        if (index_q != 2'd3) index_d = index_q + 2'd1;
      end else begin
        local_d = local_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      local_q <= '0;
      index_q <= '0;
    end else begin
      local_q <= local_d;
      index_q <= index_d;
    end
  end

  assign local_cnt = local_d;
  assign index     = index_d;
  assign in_tile   = (cnt >= 12'(Origin)) && (local_d < 12'(Size));

endmodule

// File: rtl/board_vga_compositor.sv
// 4x4 board compositor: tile addressing for the renderer and final pixel muxing.
// Optional FRAME_LATCH_EN: board is snapshotted at the start of vblank to avoid tearing.
module board_vga_compositor
  import board_vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] h_cnt,
  input  logic [11:0] v_cnt,
  input  logic [63:0] board,
  output logic [3:0]  tile_state,
  output logic [11:0] tile_h,
  output logic [11:0] tile_v,
  input  logic [11:0] block_rgb,
  output logic [11:0] vga_data
);

  logic [11:0] x_local, y_local;
  logic [1:0]  x_idx, y_idx;
  logic        x_in, y_in;
  logic        line_start;
  logic        line_ok_q, line_ok;
  logic        x_span, y_span;
  logic [63:0] board_src;
  logic [3:0]  state_sel;
  logic [11:0] vga_d;
  region_e     region;
  region_e     region_q [RENDER_LAT+1];

  assign line_start = (h_cnt == 12'd0);

  tile_axis_counter #(
    .Origin (BOARD_X0 + TILE_GAP),
    .Size   (TILE_SIZE),
    .Pitch  (TILE_PITCH)
  ) u_x_counter (
    .clk       (clk),
    .rst       (rst),
    .cnt       (h_cnt),
    .adv       (1'b1),
    .local_cnt (x_local),
    .index     (x_idx),
    .in_tile   (x_in)
  );

  tile_axis_counter #(
    .Origin (BOARD_Y0 + TILE_GAP),
    .Size   (TILE_SIZE),
    .Pitch  (TILE_PITCH)
  ) u_y_counter (
    .clk       (clk),
    .rst       (rst),
    .cnt       (v_cnt),
    .adv       (line_start),
    .local_cnt (y_local),
    .index     (y_idx),
    .in_tile   (y_in)
  );

`ifdef FRAME_LATCH_EN
  logic [63:0] snap_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_q <= '0;
    end else if (v_cnt == 12'(V_ACTIVE) && line_start) begin
      snap_q <= board;
    end
  end

  assign board_src = snap_q;
`else
  assign board_src = board;
`endif

  // After reset the horizontal counter is unknown until a line begins, so blank until then.
  assign line_ok = line_ok_q || line_start;

  assign x_span = (h_cnt >= 12'(BOARD_X0)) && (h_cnt < 12'(BOARD_X0 + BOARD_SPAN));
  assign y_span = (v_cnt >= 12'(BOARD_Y0)) && (v_cnt < 12'(BOARD_Y0 + BOARD_SPAN));

  always_comb begin
    region = TILE;
    if (!line_ok || h_cnt >= 12'(H_ACTIVE) || v_cnt >= 12'(V_ACTIVE)) begin
      region = OFF;
    end else if (!(x_span && y_span)) begin
      region = OUTSIDE;
    end else if (!(x_in && y_in)) begin
      region = GAP;
    end
  end

  assign state_sel = board_src[{y_idx, x_idx, 2'b00} +: 4];

  always_comb begin
    vga_d = COL_OFF;
    unique case (region_q[RENDER_LAT])
      TILE:    vga_d = block_rgb;
      GAP:     vga_d = COL_GAP;
      OUTSIDE: vga_d = COL_OUTSIDE;
      default: vga_d = COL_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_ok_q  <= 1'b0;
      tile_state <= '0;
      tile_h     <= '0;
      tile_v     <= '0;
      vga_data   <= '0;
      for (int unsigned i = 0; i <= RENDER_LAT; i++) region_q[i] <= OFF;
    end else begin
      if (line_start) line_ok_q <= 1'b1;
      if (region == TILE) begin
        tile_state <= state_sel;
        tile_h     <= x_local;
        tile_v     <= y_local;
      end else begin
        tile_state <= '0;
        tile_h     <= '0;
        tile_v     <= '0;
      end
      region_q[0] <= region;
      for (int unsigned i = 1; i <= RENDER_LAT; i++) region_q[i] <= region_q[i-1];
      vga_data <= vga_d;
    end
  end

endmodule
